cramer_divide: RTL
==================

# cramer_divide

Sequential signed divider for the Cramer's-rule 3x3 solver. Takes the four determinants from the determinant stage (D, Dx, Dy, Dz) through a valid/ready handshake. Computes x = Dx/D, y = Dy/D, z = Dz/D with one shared iterative restoring divider. Flags singular systems (D = 0) and quotient overflow, and holds results for the display/consumer stage downstream.

## Interface
- `W`, default 24: width of determinants and quotients (signed, two's complement).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  determinant set valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `det`, `det_x`, `det_y`, `det_z`  in  W each  D, Dx, Dy, Dz (signed).
- `out_valid`  out  1  results valid; high only in DONE.
- `out_ready`  in  1  consumer accepts results.
- `val_x`, `val_y`, `val_z`  out  W each  signed quotients.
- `singular`  out  1  D was zero.
- `ovf`  out  1  at least one quotient saturated.
- `busy`  out  1  high in SETUP/DIV/FIX.

## Operation
- States: IDLE → SETUP → (DIV → FIX) ×3 → DONE → IDLE.
- **IDLE:** `in_ready` = 1. On `in_valid & in_ready`, register all four inputs, clear `singular`/`ovf`, go to SETUP. Inputs are sampled only at this accept edge.
- **SETUP:**
  - If D == 0: `val_*` = 0, `singular` = 1, go to DONE.
  - Otherwise: latch |D|, sign of D, |Dx| and sign of Dx, clear partial remainder, set numerator index = 0, go to DIV.
- **DIV:** W iterations, one quotient bit per cycle, MSB first. Restoring step: remainder = {remainder, next numerator bit}; if remainder ≥ |D|, subtract and set bit. The remainder register is W+1 bits. Magnitudes are unsigned W bits, so |−2^(W−1)| = 2^(W−1) is represented exactly.
- **FIX** (1 cycle):
  - Result sign = sign(N) XOR sign(D).
  - Apply optional rounding (see Configuration).
  - If the signed result magnitude exceeds range, saturate: positive to 2^(W−1)−1, negative to −2^(W−1), and set `ovf` = 1 (sticky until next accept).
  - Write to `val_x`/`val_y`/`val_z` by index.
  - If index < 2, load the next numerator magnitude and sign, increment index, go to DIV. Otherwise go to DONE.
- **DONE:** `out_valid` = 1; `val_*`, `singular`, `ovf` stable. On `out_ready`, go to IDLE.
- After handshake, `val_*`, `singular`, `ovf` keep their values until the next accept.
- `in_valid` outside IDLE is ignored; it is not queued.

## Timing
- Reset (`rst_n` low at a rising edge): state = IDLE; `in_ready` = 1; `out_valid`, `busy`, `singular`, `ovf` = 0; `val_x`/`val_y`/`val_z` = 0; all internal registers cleared.
- Reset mid-operation aborts immediately with no partial result visible.
- Latency is counted in rising edges from the accept edge to `out_valid` high:
  - Normal: 1 + 3(W+1) = 3W+4 (76 for W = 24).
  - Singular: 1.
- Minimum initiation interval: latency + 1 (DONE) + 1 (IDLE) cycles with `out_ready` held high.
- `out_valid` and `in_ready` are never high in the same cycle.
- `out_ready` outside DONE is ignored.
- `busy` is registered and equals (state ∈ {SETUP, DIV, FIX}).

## Configuration
- Macro: `CRAMER_DIV_ROUND_EN`.
- **Defined:** FIX rounds half away from zero. If 2·rem ≥ |D|, the magnitude is incremented before the sign is applied. An increment that overflows range saturates and sets `ovf`. Rounding logic is one comparator and one incrementer in FIX; latency is unchanged.
- **Undefined:** quotients truncate toward zero, matching Verilog signed `/`. No rounding logic is synthesized.

## Test plan
1. D=6, Dx=12, Dy=−18, Dz=9, `out_ready`=1 → after 76 edges: `val_x`=2, `val_y`=−3, `val_z`=1 (2 with `CRAMER_DIV_ROUND_EN`); `singular`=0, `ovf`=0.
2. D=0, Dx=5, Dy=5, Dz=5 → `out_valid` 1 edge after accept; `val_*`=0, `singular`=1, `busy` never high after SETUP.
3. D=−1, Dx=−8388608, Dy=7, Dz=0 → `val_x`=8388607, `ovf`=1, `val_y`=−7, `val_z`=0.
4. Backpressure: after result, hold `out_ready`=0 for 10 cycles and pulse `in_valid` with new data → `out_valid` stays 1, `val_*` unchanged, `in_ready`=0, new data not accepted; release `out_ready` → IDLE next edge.
5. Reset mid-op: assert `rst_n`=0 at edge 30 after accept of case 1 → next cycle all outputs 0, `in_ready`=1; rerun case 1 → correct results at 76 edges.
6. Sign sweep: D=−7, Dx=22, Dy=−22, Dz=−3 → truncate: −3, 3, 0; round: −3, 3, 0 (|rem|·2 = 2·1 < 7, and 6 < 7 for Dz).

Source files
------------

// File: rtl/cramer_divide.sv
// Signed Cramer's-rule divider: x=Dx/D, y=Dy/D, z=Dz/D on one shared iterative restoring divider.
// Latency 3W+4 edges from accept to out_valid (1 when D==0); in_ready only in IDLE, results held in DONE until out_ready.
// Optional round-half-away-from-zero in FIX under macro CRAMER_DIV_ROUND_EN (default: truncate toward zero).
module cramer_divide #(
    parameter int W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] det,
    input  logic signed [W-1:0] det_x,
    input  logic signed [W-1:0] det_y,
    input  logic signed [W-1:0] det_z,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] val_x,
    output logic signed [W-1:0] val_y,
    output logic signed [W-1:0] val_z,
    output logic                singular,
    output logic                ovf,
    output logic                busy
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST    = CW'(W - 1);
    localparam logic [W:0]    MAG_NEG_LIM = {2'b01, {(W-1){1'b0}}};
    localparam logic [W:0]    MAG_POS_LIM = {2'b00, {(W-1){1'b1}}};
    localparam logic [W-1:0]  SAT_NEG     = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  SAT_POS     = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [W-1:0]   det_q, dx_q, dy_q, dz_q;
    logic [W-1:0]   dmag_q;
    logic           dneg_q;
    logic [W-1:0]   num_q;
    logic           nneg_q;
    logic [W:0]     rem_q;
    logic [W-1:0]   quo_q;
    logic [CW-1:0]  cnt_q;
    logic [1:0]     idx_q;
    logic [W-1:0]   val_x_q, val_y_q, val_z_q;
    logic           singular_q, ovf_q, in_ready_q, out_valid_q, busy_q;

    function automatic logic [W-1:0] mag_of(input logic [W-1:0] v);
        mag_of = v[W-1] ? (~v + {{(W-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Restoring step: shift in the next numerator bit, subtract when it fits.
    logic [W:0]   rem_shift_d;
    logic         rem_ge_d;
    logic [W:0]   rem_sub_d;
    assign rem_shift_d = (rem_q << 1) | {{W{1'b0}}, num_q[W-1]};
    assign rem_ge_d    = rem_shift_d >= {1'b0, dmag_q};
    assign rem_sub_d   = rem_shift_d - {1'b0, dmag_q};

    logic [W:0]   fix_mag_d;
`ifdef CRAMER_DIV_ROUND_EN
    logic         round_up_d;
    assign round_up_d = {rem_q, 1'b0} >= {2'b00, dmag_q};
    assign fix_mag_d  = {1'b0, quo_q} + {{W{1'b0}}, round_up_d};
`else
    assign fix_mag_d  = {1'b0, quo_q};
`endif

    // Magnitude is W+1 bits so a rounded 2^(W-1) (or 2^(W-1) from |-2^(W-1)|/1) is caught before the sign.
    logic         fix_neg_d;
    logic         fix_sat_d;
    logic [W-1:0] fix_val_d;
    assign fix_neg_d = nneg_q ^ dneg_q;
    assign fix_sat_d = fix_neg_d ? (fix_mag_d > MAG_NEG_LIM) : (fix_mag_d > MAG_POS_LIM);
    assign fix_val_d = fix_sat_d ? (fix_neg_d ? SAT_NEG : SAT_POS)
                                 : (fix_neg_d ? (~fix_mag_d[W-1:0] + {{(W-1){1'b0}}, 1'b1})
                                              : fix_mag_d[W-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            det_q       <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            dz_q        <= '0;
            dmag_q      <= '0;
            dneg_q      <= 1'b0;
            num_q       <= '0;
            nneg_q      <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            val_x_q     <= '0;
            val_y_q     <= '0;
            val_z_q     <= '0;
            singular_q  <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        det_q      <= det;
                        dx_q       <= det_x;
                        dy_q       <= det_y;
                        dz_q       <= det_z;
                        singular_q <= 1'b0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (det_q == '0) begin
                        val_x_q     <= '0;
                        val_y_q     <= '0;
                        val_z_q     <= '0;
                        singular_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        dmag_q  <= mag_of(det_q);
                        dneg_q  <= det_q[W-1];
                        num_q   <= mag_of(dx_q);
                        nneg_q  <= dx_q[W-1];
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_ge_d ? rem_sub_d : rem_shift_d;
                    quo_q <= {quo_q[W-2:0], rem_ge_d};
                    num_q <= num_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    case (idx_q)
                        2'd0:    val_x_q <= fix_val_d;
                        2'd1:    val_y_q <= fix_val_d;
                        default: val_z_q <= fix_val_d;
                    endcase
                    if (fix_sat_d) begin
                        ovf_q <= 1'b1;
                    end
                    if (idx_q != 2'd2) begin
                        num_q   <= mag_of((idx_q == 2'd0) ? dy_q : dz_q);
                        nneg_q  <= (idx_q == 2'd0) ? dy_q[W-1] : dz_q[W-1];
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 2'd1;
                        state_q <= S_DIV;
                    end else begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign val_x     = val_x_q;
    assign val_y     = val_y_q;
    assign val_z     = val_z_q;
    assign singular  = singular_q;
    assign ovf       = ovf_q;

endmodule
